// File: rtl/msx_audio_mixer.sv
// msx_audio_mixer
// Captures PSG, SCC, OPLL and key-click levels on a sample strobe, scales each
// by a 4-bit gain (8 = unity) and sums them with one shared multiplier over
// four cycles. The 20-bit sum is clamped to a signed 16-bit output sample.
//
// Handshake: clk_en is a single-cycle request with no back-pressure. It is
// accepted only in IDLE or DONE. In M0..M3 it is discarded and sets the sticky
// dropped flag. audio_valid is a one-cycle pulse, with no ready, and it is
// asserted on the edge that updates audio_out. audio_out holds between pulses.
module msx_audio_mixer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [9:0]  psg_wave,
  input  logic [15:0] scc_wave,
  input  logic [15:0] opll_wave,
  input  logic        click,
  input  logic        mute,
  input  logic [3:0]  gain_psg,
  input  logic [3:0]  gain_scc,
  input  logic [3:0]  gain_opll,
  input  logic [3:0]  gain_click,
  output logic [15:0] audio_out,
  output logic        audio_valid,
  output logic        dropped,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_M0   = 3'd1,
    S_M1   = 3'd2,
    S_M2   = 3'd3,
    S_M3   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic signed [19:0] SAT_MAX = 20'sd32767;
  localparam logic signed [19:0] SAT_MIN = -20'sd32768;
  localparam logic signed [15:0] PSG_OFFSET = 16'sd16384;
  localparam logic signed [15:0] CLICK_LEVEL = 16'sd4096;

  state_t r_state;
  state_t w_state_next;

  // Latched copy of one sample's inputs, stable for the whole MAC sequence.
  logic [9:0]  r_psg;
  logic [15:0] r_scc;
  logic [15:0] r_opll;
  logic        r_click;
  logic        r_mute;
  logic [3:0]  r_gain_psg;
  logic [3:0]  r_gain_scc;
  logic [3:0]  r_gain_opll;
  logic [3:0]  r_gain_click;

  logic signed [19:0] r_acc;
  logic [15:0]        r_audio_out;
  logic               r_audio_valid;
  logic               r_dropped;

  logic               w_accept;
  logic               w_busy;
  logic signed [15:0] w_psg_s;
  logic signed [15:0] w_click_s;
  logic signed [15:0] w_sample;
  logic [3:0]         w_gain;
  logic signed [19:0] w_sample_ext;
  logic signed [19:0] w_gain_ext;
  logic signed [19:0] w_product;
  logic signed [19:0] w_term;
  logic [15:0]        w_sat;

  assign w_busy   = (r_state == S_M0) || (r_state == S_M1) ||
                    (r_state == S_M2) || (r_state == S_M3);
  assign w_accept = clk_en && ((r_state == S_IDLE) || (r_state == S_DONE));

  // Source conversion: PSG is unsigned and gets re-centred around zero.
  assign w_psg_s   = $signed({1'b0, r_psg, 5'b0}) - PSG_OFFSET;
  assign w_click_s = r_click ? CLICK_LEVEL : 16'sd0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: fixed four-step walk, re-entering M0 straight from DONE
  // when a new strobe is already waiting.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = clk_en ? S_M0 : S_IDLE;
      S_M0:    w_state_next = S_M1;
      S_M1:    w_state_next = S_M2;
      S_M2:    w_state_next = S_M3;
      S_M3:    w_state_next = S_DONE;
      S_DONE:  w_state_next = clk_en ? S_M0 : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand mux feeding the shared multiplier, one source per MAC state.
  always_comb begin
    w_sample = 16'sd0;
    w_gain   = 4'd0;
    case (r_state)
      S_M0: begin
        w_sample = w_psg_s;
        w_gain   = r_gain_psg;
      end
      S_M1: begin
        w_sample = $signed(r_scc);
        w_gain   = r_gain_scc;
      end
      S_M2: begin
        w_sample = $signed(r_opll);
        w_gain   = r_gain_opll;
      end
      S_M3: begin
        w_sample = w_click_s;
        w_gain   = r_gain_click;
      end
      default: begin
        w_sample = 16'sd0;
        w_gain   = 4'd0;
      end
    endcase
  end

  // |sample * gain| <= 32768 * 15 < 2^19, so a 20-bit signed product is exact.
  assign w_sample_ext = {{4{w_sample[15]}}, w_sample};
  assign w_gain_ext   = $signed({16'b0, w_gain});
  assign w_product    = w_sample_ext * w_gain_ext;
  // Arithmetic shift floors toward minus infinity (-1 * 1 >>> 3 = -1).
  assign w_term       = w_product >>> 3;

  // Clamp the accumulated sum into the signed 16-bit output range.
  always_comb begin
    w_sat = r_acc[15:0];
    if (r_acc > SAT_MAX) begin
      w_sat = 16'h7FFF;
    end else if (r_acc < SAT_MIN) begin
      w_sat = 16'h8000;
    end
  end

  // Input capture: only an accepted strobe updates the latched sample set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_psg        <= '0;
      r_scc        <= '0;
      r_opll       <= '0;
      r_click      <= 1'b0;
      r_mute       <= 1'b0;
      r_gain_psg   <= '0;
      r_gain_scc   <= '0;
      r_gain_opll  <= '0;
      r_gain_click <= '0;
    end else if (w_accept) begin
      r_psg        <= psg_wave;
      r_scc        <= scc_wave;
      r_opll       <= opll_wave;
      r_click      <= click;
      r_mute       <= mute;
      r_gain_psg   <= gain_psg;
      r_gain_scc   <= gain_scc;
      r_gain_opll  <= gain_opll;
      r_gain_click <= gain_click;
    end
  end

  // Accumulator: cleared on accept, one scaled term added per MAC state.
  // Four terms of at most 61440 each cannot overflow 20 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
    end else if (w_busy) begin
      r_acc <= r_acc + w_term;
    end
  end

  // Output stage: publish the clamped (or muted) sum for one cycle in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_audio_out   <= '0;
      r_audio_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_audio_out   <= r_mute ? 16'h0000 : w_sat;
      r_audio_valid <= 1'b1;
    end else begin
      r_audio_valid <= 1'b0;
    end
  end

  // Sticky drop flag: any strobe arriving mid-sequence is lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dropped <= 1'b0;
    end else if (clk_en && w_busy) begin
      r_dropped <= 1'b1;
    end
  end

  assign audio_out   = r_audio_out;
  assign audio_valid = r_audio_valid;
  assign dropped     = r_dropped;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_msx_audio_mixer.sv
// Bench for msx_audio_mixer: directed vector table, randomized vectors scored
// against an arithmetic reference model, and multi-cycle drop/abort sequences.
module tb_msx_audio_mixer;

  typedef struct {
    logic [9:0]  psg;
    logic [15:0] scc;
    logic [15:0] opll;
    logic        click;
    logic        mute;
    logic [3:0]  gp;
    logic [3:0]  gs;
    logic [3:0]  go;
    logic [3:0]  gc;
    int          exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic [9:0]  psg_wave;
  logic [15:0] scc_wave;
  logic [15:0] opll_wave;
  logic        click;
  logic        mute;
  logic [3:0]  gain_psg;
  logic [3:0]  gain_scc;
  logic [3:0]  gain_opll;
  logic [3:0]  gain_click;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic        dropped;
  logic [2:0]  dbg_state;

  int n_total;
  int n_pass;
  logic [15:0] exp_q[$];
  vec_t vecs[10];

  msx_audio_mixer dut (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .psg_wave   (psg_wave),
    .scc_wave   (scc_wave),
    .opll_wave  (opll_wave),
    .click      (click),
    .mute       (mute),
    .gain_psg   (gain_psg),
    .gain_scc   (gain_scc),
    .gain_opll  (gain_opll),
    .gain_click (gain_click),
    .audio_out  (audio_out),
    .audio_valid(audio_valid),
    .dropped    (dropped),
    .o_dbg_state(dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int floor_div8(input int x);
    int q;
    q = x / 8;
    if ((x % 8 != 0) && (x < 0)) q = q - 1;
    return q;
  endfunction

  // Reference model: convert each source to a signed level, scale, sum, clamp.
  function automatic int ref_mix(input vec_t v);
    int p, s, o, c, sum;
    p = int'(v.psg) * 32 - 16384;
    s = int'($signed(v.scc));
    o = int'($signed(v.opll));
    c = v.click ? 4096 : 0;
    sum = floor_div8(p * int'(v.gp)) + floor_div8(s * int'(v.gs)) +
          floor_div8(o * int'(v.go)) + floor_div8(c * int'(v.gc));
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    if (v.mute) sum = 0;
    return sum;
  endfunction

  // Driver tasks.
  task automatic drive(input vec_t v);
    psg_wave   = v.psg;
    scc_wave   = v.scc;
    opll_wave  = v.opll;
    click      = v.click;
    mute       = v.mute;
    gain_psg   = v.gp;
    gain_scc   = v.gs;
    gain_opll  = v.go;
    gain_click = v.gc;
  endtask

  task automatic scramble();
    psg_wave   = 10'($urandom);
    scc_wave   = 16'($urandom);
    opll_wave  = 16'($urandom);
    click      = 1'($urandom);
    mute       = 1'($urandom);
    gain_psg   = 4'($urandom);
    gain_scc   = 4'($urandom);
    gain_opll  = 4'($urandom);
    gain_click = 4'($urandom);
  endtask

  function automatic vec_t mk(input int psg, input int scc, input int opll,
                              input int clk_b, input int mu, input int gp,
                              input int gs, input int go, input int gc,
                              input int exp);
    vec_t v;
    v.psg = 10'(psg); v.scc = 16'(scc); v.opll = 16'(opll);
    v.click = 1'(clk_b); v.mute = 1'(mu);
    v.gp = 4'(gp); v.gs = 4'(gs); v.go = 4'(go); v.gc = 4'(gc);
    v.exp = exp;
    return v;
  endfunction

  // One strobe, then inputs scrambled; expect a single pulse exactly at E5.
  task automatic run_vec(input vec_t v, input string name);
    int pulses;
    logic [15:0] exp;
    if (exp_q.size() == 0) begin
      check({name, ".queue"}, 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    drive(v);
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    scramble();
    pulses = 0;
    repeat (4) begin
      tick();
      if (audio_valid) pulses++;
    end
    check({name, ".early"}, pulses, 0);
    tick();
    check({name, ".valid"}, int'(audio_valid), 1);
    check({name, ".out"}, int'($signed(audio_out)), int'($signed(exp)));
    tick();
    check({name, ".deassert"}, int'(audio_valid), 0);
  endtask

  initial begin
    vec_t v;
    int pulses, first_at;
    n_total = 0;
    n_pass  = 0;
    clk_en  = 1'b0;

    // Reset with every input nonzero and a strobe present.
    reset = 1'b1;
    drive(mk(1023, 1000, 2000, 1, 1, 8, 8, 8, 8, 0));
    clk_en = 1'b1;
    repeat (3) tick();
    check("reset.out", int'(audio_out), 0);
    check("reset.valid", int'(audio_valid), 0);
    check("reset.dropped", int'(dropped), 0);
    reset  = 1'b0;
    clk_en = 1'b0;
    pulses = 0;
    repeat (10) begin
      tick();
      if (audio_valid) pulses++;
    end
    check("reset.quiet", pulses, 0);

    // Directed table.
    vecs[0] = mk(0,    1000,  0,     0, 0, 0, 8,  0,  0, 1000);
    vecs[1] = mk(0,    32767, 32767, 0, 0, 0, 15, 15, 0, 32767);
    vecs[2] = mk(0,    32768, 32768, 0, 0, 0, 15, 15, 0, -32768);
    vecs[3] = mk(0,    0,     0,     0, 0, 8, 0,  0,  0, -16384);
    vecs[4] = mk(1023, 0,     0,     0, 0, 8, 0,  0,  0, 16352);
    vecs[5] = mk(0,    0,     0,     1, 0, 0, 0,  0,  8, 4096);
    vecs[6] = mk(0,    65535, 0,     0, 0, 0, 1,  0,  0, -1);
    vecs[7] = mk(0,    7,     0,     0, 0, 0, 1,  0,  0, 0);
    vecs[8] = mk(0,    1000,  0,     0, 1, 0, 8,  0,  0, 0);
    vecs[9] = mk(512,  2000,  64736, 1, 0, 9, 4,  12, 15, 7480);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'(vecs[i].exp));
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end
    check("table.no_drop", int'(dropped), 0);

    // Randomized vectors against the reference model.
    for (int i = 0; i < 40; i++) begin
      v = mk($urandom_range(1023), $urandom_range(65535), $urandom_range(65535),
             $urandom_range(1), ($urandom_range(7) == 0) ? 1 : 0,
             $urandom_range(15), $urandom_range(15), $urandom_range(15),
             $urandom_range(15), 0);
      exp_q.push_back(16'(ref_mix(v)));
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // Strobes at E0 and E2: one result from E0 inputs, dropped set.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(mk(0, 1000, 0, 0, 0, 0, 8, 0, 0, 0));
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    drive(mk(0, 5000, 0, 0, 0, 0, 8, 0, 0, 0));
    pulses = 0;
    first_at = -1;
    for (int e = 1; e <= 10; e++) begin
      clk_en = (e == 2) ? 1'b1 : 1'b0;
      tick();
      if (audio_valid) begin
        pulses++;
        if (first_at < 0) first_at = e;
      end
      if (e == 5) check("drop.out", int'($signed(audio_out)), 1000);
    end
    check("drop.pulses", pulses, 1);
    check("drop.edge", first_at, 5);
    check("drop.flag", int'(dropped), 1);

    // Strobe at E0, reset at E3: aborted, no pulse, output stays 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(mk(0, 1000, 0, 0, 0, 0, 8, 0, 0, 0));
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    pulses = 0;
    for (int e = 1; e <= 12; e++) begin
      reset = (e == 3) ? 1'b1 : 1'b0;
      tick();
      if (audio_valid) pulses++;
    end
    check("abort.pulses", pulses, 0);
    check("abort.out", int'(audio_out), 0);
    check("abort.dropped", int'(dropped), 0);

    // clk_en held high: one result every 5 clocks, strobe in DONE accepted.
    drive(mk(0, 300, 0, 0, 0, 0, 8, 0, 0, 0));
    clk_en = 1'b1;
    pulses = 0;
    first_at = -1;
    for (int e = 0; e <= 16; e++) begin
      clk_en = (e <= 14) ? 1'b1 : 1'b0;
      tick();
      if (audio_valid) begin
        pulses++;
        if (first_at < 0) first_at = e;
      end
    end
    check("stream.pulses", pulses, 3);
    check("stream.first", first_at, 5);
    check("stream.out", int'($signed(audio_out)), 300);
    check("stream.dropped", int'(dropped), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
